ram_port_arbiter: RTL and testbench

//  Shares the single read port and single write port of emb_ram between the pipeline core (C)
//  and a secondary bus master (D: DMA or debug loader). Sits between test_pipeline_assembly
//  and emb_ram inside the processor assembly. C has fixed priority. A per-port starvation

---
 rtl/ram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Shares emb_ram's read and write ports between the core (C, fixed
//            priority) and a secondary master (D) with starvation-forced grants.
// Revision : 1.0 - initial release
// ============================================================================

// Per-port arbiter: C wins in NORMAL; D is forced for one cycle after
// STARVE_MAX consecutive denials, stalling C if both request.
module ram_port_arbiter_port #(
  parameter int STARVE_MAX = 4,
  parameter int CW         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_c_req,
  input  logic i_d_req,
  output logic o_c_gnt,
  output logic o_d_gnt,
  output logic o_stall
);

  localparam logic [CW-1:0] c_LAST = CW'(STARVE_MAX - 1);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_FORCE_D = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_NORMAL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_NORMAL;
    w_cnt_nxt   = '0;
    o_c_gnt     = 1'b0;
    o_d_gnt     = 1'b0;
    o_stall     = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        o_c_gnt = i_c_req;
        o_d_gnt = i_d_req & ~i_c_req;
        // Counter only survives a cycle in which D was actually denied.
        if (i_d_req && i_c_req) begin
          if (r_cnt == c_LAST) begin
            w_state_nxt = ST_FORCE_D;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_FORCE_D: begin
        o_d_gnt = i_d_req;
        o_c_gnt = i_c_req & ~i_d_req;
        o_stall = i_c_req & i_d_req;
      end
      default: begin
        w_state_nxt = ST_NORMAL;
      end
    endcase
  end

endmodule

module ram_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] c_r_addr,
  input  logic [AW-1:0] c_w_addr,
  input  logic [DW-1:0] c_w_line,
  input  logic          c_read,
  input  logic          c_write,
  output logic [DW-1:0] c_r_line,
  output logic          c_exception,
  output logic          c_stall,
  input  logic [AW-1:0] d_r_addr,
  input  logic [AW-1:0] d_w_addr,
  input  logic [DW-1:0] d_w_line,
  input  logic          d_read,
  input  logic          d_write,
  output logic          d_r_gnt,
  output logic          d_w_gnt,
  output logic          d_r_valid,
  output logic [DW-1:0] d_r_line,
  output logic          d_exception,
  output logic [AW-1:0] ram_r_addr,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_line,
  output logic          ram_read,
  output logic          ram_write,
  input  logic [DW-1:0] ram_r_line,
  input  logic          ram_exception
);

  logic w_c_r_gnt;
  logic w_c_w_gnt;
  logic w_r_stall;
  logic w_w_stall;
  logic r_rd_valid;
  logic r_rd_owner_d;

  ram_port_arbiter_port #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (CW)
  ) u_rd_port (
    .clk     (clk),
    .rst     (rst),
    .i_c_req (c_read),
    .i_d_req (d_read),
    .o_c_gnt (w_c_r_gnt),
    .o_d_gnt (d_r_gnt),
    .o_stall (w_r_stall)
  );

  ram_port_arbiter_port #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (CW)
  ) u_wr_port (
    .clk     (clk),
    .rst     (rst),
    .i_c_req (c_write),
    .i_d_req (d_write),
    .o_c_gnt (w_c_w_gnt),
    .o_d_gnt (d_w_gnt),
    .o_stall (w_w_stall)
  );

  assign c_stall = w_r_stall | w_w_stall;

  // Buses default to the core values when D is not granted.
  assign ram_r_addr = d_r_gnt ? d_r_addr : c_r_addr;
  assign ram_w_addr = d_w_gnt ? d_w_addr : c_w_addr;
  assign ram_w_line = d_w_gnt ? d_w_line : c_w_line;
  assign ram_read   = w_c_r_gnt | d_r_gnt;
  assign ram_write  = w_c_w_gnt | d_w_gnt;

  assign c_exception = ram_exception & (w_c_r_gnt | w_c_w_gnt);
  assign d_exception = ram_exception & (d_r_gnt | d_w_gnt);

  // Owner is held between reads; valid marks the cycle data actually returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid   <= 1'b0;
      r_rd_owner_d <= 1'b0;
    end else begin
      r_rd_valid <= ram_read;
      if (ram_read) begin
        r_rd_owner_d <= d_r_gnt;
      end
    end
  end

  assign c_r_line  = ram_r_line;
  assign d_r_line  = ram_r_line;
  assign d_r_valid = r_rd_valid & r_rd_owner_d;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed and randomized self-checking bench for ram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int CW         = 3;

  logic          clk;
  logic          rst;
  logic [AW-1:0] c_r_addr, c_w_addr, d_r_addr, d_w_addr;
  logic [DW-1:0] c_w_line, d_w_line, ram_r_line;
  logic          c_read, c_write, d_read, d_write, ram_exception;
  logic [DW-1:0] c_r_line, d_r_line, ram_w_line;
  logic [AW-1:0] ram_r_addr, ram_w_addr;
  logic          c_exception, c_stall, d_r_gnt, d_w_gnt, d_r_valid, d_exception;
  logic          ram_read, ram_write;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: denial streak per port and a one-shot force flag.
  int m_streak [2];
  bit m_force  [2];
  bit m_dvalid;

  ram_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .c_r_addr(c_r_addr), .c_w_addr(c_w_addr), .c_w_line(c_w_line),
    .c_read(c_read), .c_write(c_write),
    .c_r_line(c_r_line), .c_exception(c_exception), .c_stall(c_stall),
    .d_r_addr(d_r_addr), .d_w_addr(d_w_addr), .d_w_line(d_w_line),
    .d_read(d_read), .d_write(d_write),
    .d_r_gnt(d_r_gnt), .d_w_gnt(d_w_gnt), .d_r_valid(d_r_valid),
    .d_r_line(d_r_line), .d_exception(d_exception),
    .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_line(ram_w_line),
    .ram_read(ram_read), .ram_write(ram_write),
    .ram_r_line(ram_r_line), .ram_exception(ram_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_streak[p] = 0;
      m_force[p]  = 1'b0;
    end
    m_dvalid = 1'b0;
  endfunction

  // Who wins a port this cycle, from the model's point of view.
  function automatic void model_arb(input int p, input bit c, input bit d,
                                    output bit cg, output bit dg, output bit st);
    if (m_force[p]) begin
      dg = d;
      cg = c && !d;
      st = c && d;
    end else begin
      cg = c;
      dg = d && !c;
      st = 1'b0;
    end
  endfunction

  function automatic void model_tick(input int p, input bit c, input bit d);
    if (m_force[p]) begin
      m_force[p]  = 1'b0;
      m_streak[p] = 0;
    end else if (c && d) begin
      m_streak[p] = m_streak[p] + 1;
      if (m_streak[p] >= STARVE_MAX) begin
        m_force[p]  = 1'b1;
        m_streak[p] = 0;
      end
    end else begin
      m_streak[p] = 0;
    end
  endfunction

  // Inputs are already set at a negedge; check, clock once, return at next negedge.
  task automatic run_cycle();
    bit cgr, dgr, str, cgw, dgw, stw;
    #1;
    model_arb(0, c_read,  d_read,  cgr, dgr, str);
    model_arb(1, c_write, d_write, cgw, dgw, stw);
    chk("d_r_gnt",     d_r_gnt,     dgr);
    chk("d_w_gnt",     d_w_gnt,     dgw);
    chk("c_stall",     c_stall,     str || stw);
    chk("ram_read",    ram_read,    cgr || dgr);
    chk("ram_write",   ram_write,   cgw || dgw);
    chk("ram_r_addr",  ram_r_addr,  dgr ? d_r_addr : c_r_addr);
    chk("ram_w_addr",  ram_w_addr,  dgw ? d_w_addr : c_w_addr);
    chk("ram_w_line",  ram_w_line,  dgw ? d_w_line : c_w_line);
    chk("c_exception", c_exception, ram_exception && (cgr || cgw));
    chk("d_exception", d_exception, ram_exception && (dgr || dgw));
    chk("d_r_valid",   d_r_valid,   m_dvalid);
    chk("c_r_line",    c_r_line,    ram_r_line);
    chk("d_r_line",    d_r_line,    ram_r_line);
    @(posedge clk);
    if (rst) begin
      model_tick(0, c_read,  d_read);
      model_tick(1, c_write, d_write);
      m_dvalid = dgr;
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c_read = 1'b0; c_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    ram_exception = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    c_r_addr = '0; c_w_addr = '0; c_w_line = '0;
    d_r_addr = '0; d_w_addr = '0; d_w_line = '0;
    ram_r_line = '0;
    idle_inputs();
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_d_r_valid", d_r_valid, 1'b0);
    chk("rst_c_stall",   c_stall,   1'b0);
    chk("rst_ram_read",  ram_read,  1'b0);
    chk("rst_ram_write", ram_write, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 1. Core read only
    c_read = 1'b1; c_r_addr = 32'h10;
    #1;
    chk("t1_ram_r_addr", ram_r_addr, 32'h10);
    chk("t1_ram_read",   ram_read,   1'b1);
    chk("t1_c_stall",    c_stall,    1'b0);
    run_cycle();
    ram_r_line = 32'hCAFE_0010; c_read = 1'b0;
    #1;
    chk("t1_c_r_line", c_r_line, 32'hCAFE_0010);
    run_cycle();

    // 2. D write with core idle
    d_write = 1'b1; d_w_addr = 32'h20; d_w_line = 32'hDEAD_BEEF;
    #1;
    chk("t2_d_w_gnt",     d_w_gnt,    1'b1);
    chk("t2_ram_w_line",  ram_w_line, 32'hDEAD_BEEF);
    chk("t2_ram_w_addr",  ram_w_addr, 32'h20);
    run_cycle();
    idle_inputs();

    // 3. Continuous C+D reads: 4 denials then one forced grant, twice over
    c_read = 1'b1; d_read = 1'b1; d_r_addr = 32'h300; c_r_addr = 32'h100;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_d_r_gnt", d_r_gnt, ((i % 5) == 4) ? 1'b1 : 1'b0);
      chk("t3_c_stall", c_stall, ((i % 5) == 4) ? 1'b1 : 1'b0);
      chk("t3_d_r_valid", d_r_valid, ((i % 5) == 0 && i > 0) ? 1'b1 : 1'b0);
      run_cycle();
    end
    idle_inputs();
    run_cycle();

    // 4. C reads while D writes: both granted, no starvation accrues
    for (int i = 0; i < 3; i++) begin
      c_read = 1'b1; d_write = 1'b1; d_w_line = $urandom;
      #1;
      chk("t4_d_w_gnt", d_w_gnt, 1'b1);
      chk("t4_c_stall", c_stall, 1'b0);
      run_cycle();
    end
    idle_inputs();

    // 5. Exception on a granted D write goes only to D
    d_write = 1'b1; ram_exception = 1'b1;
    #1;
    chk("t5_d_exception", d_exception, 1'b1);
    chk("t5_c_exception", c_exception, 1'b0);
    run_cycle();
    idle_inputs();
    run_cycle();

    // Randomized traffic, biased toward contention
    for (int i = 0; i < 400; i++) begin
      c_read   = ($urandom_range(0, 99) < 70);
      c_write  = ($urandom_range(0, 99) < 60);
      d_read   = ($urandom_range(0, 99) < 65);
      d_write  = ($urandom_range(0, 99) < 55);
      c_r_addr = $urandom; c_w_addr = $urandom; c_w_line = $urandom;
      d_r_addr = $urandom; d_w_addr = $urandom; d_w_line = $urandom;
      ram_r_line    = $urandom;
      ram_exception = ($urandom_range(0, 99) < 20);
      run_cycle();
    end
    idle_inputs();
    run_cycle();

    // 6. Reset while the read port is forcing a D grant
    c_read = 1'b1; d_read = 1'b1;
    for (int i = 0; i < 10 && !m_force[0]; i++) begin
      run_cycle();
    end
    #1;
    chk("t6_force_gnt",   d_r_gnt, 1'b1);
    chk("t6_force_stall", c_stall, 1'b1);
    rst = 1'b0;
    #1;
    chk("t6_rst_d_r_gnt", d_r_gnt, 1'b0);
    chk("t6_rst_c_stall", c_stall, 1'b0);
    @(posedge clk);
    #1;
    chk("t6_rst_d_r_valid", d_r_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; d_read = 1'b0; c_r_addr = 32'h44;
    #1;
    chk("t6_c_granted", ram_read,   1'b1);
    chk("t6_c_addr",    ram_r_addr, 32'h44);
    run_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
